// File: rtl/ula_pkg.sv
// Shared definitions for the ula integer ALU: opcode map, reserved range,
// compare-result encodings and a small helper for the CMP result.
package ula_pkg;

  localparam int unsigned OPCODE_W          = 4;
  localparam int unsigned DATA_SIZE_DEFAULT = 11;

  typedef logic [OPCODE_W-1:0] opcode_t;

  // Operation select values
  localparam opcode_t OP_ADD  = 4'd0;
  localparam opcode_t OP_SUB  = 4'd1;
  localparam opcode_t OP_MUL  = 4'd2;
  localparam opcode_t OP_DIV  = 4'd3;
  localparam opcode_t OP_AND  = 4'd4;
  localparam opcode_t OP_NAND = 4'd5;
  localparam opcode_t OP_OR   = 4'd6;
  localparam opcode_t OP_XOR  = 4'd7;
  localparam opcode_t OP_CMP  = 4'd8;
  localparam opcode_t OP_NOT  = 4'd9;

  // Opcodes 10..15 are unused and produce a zero result
  localparam opcode_t OP_RSVD_FIRST = 4'd10;
  localparam opcode_t OP_RSVD_LAST  = 4'd15;

  // Compare result as a 2-bit signed code; sign-extending it to the data
  // width yields 0 (equal), 1 (greater) or all ones (less).
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b11
  } cmp_res_e;

  // Map an unsigned greater/equal pair onto the compare code
  function automatic cmp_res_e cmp_encode(input logic gt, input logic eq);
    cmp_res_e res;
    if (gt) begin
      res = CMP_GT;
    end else if (eq) begin
      res = CMP_EQ;
    end else begin
      res = CMP_LT;
    end
    return res;
  endfunction

endpackage : ula_pkg

// File: rtl/ula_div.sv
// Unsigned combinational restoring divider.
// Ports:
//   dividend       in  W  numerator (unsigned)
//   divisor        in  W  denominator (unsigned)
//   quotient_c     out W  floor(dividend/divisor); all ones when divisor is 0
//   div_by_zero_c  out 1  divisor is zero
// Outputs are combinational; the whole division settles within one cycle.
module ula_div
  import ula_pkg::*;
#(
  parameter int unsigned W = DATA_SIZE_DEFAULT
) (
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient_c,
  output logic         div_by_zero_c
);

  // Partial remainder is one bit wider so the shifted value never overflows
  logic [W:0] rem;

  // Long division, one quotient bit per dividend bit, MSB first
  always_comb begin
    rem           = '0;
    quotient_c    = '0;
    div_by_zero_c = (divisor == '0);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      rem = {rem[W-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem           = rem - {1'b0, divisor};
        quotient_c[i] = 1'b1;
      end
    end
    // The loop already yields all ones for a zero divisor; forced for clarity
    if (div_by_zero_c) begin
      quotient_c = '1;
    end
  end

endmodule : ula_div

// File: rtl/ula.sv
// Parameterised unsigned integer ALU with a single registered result.
// Ports:
//   clk        in  1          rising-edge clock
//   rst        in  1          synchronous active-high reset, clears out
//   operand_a  in  DATA_SIZE  operand A (unsigned)
//   operand_b  in  DATA_SIZE  operand B (unsigned)
//   opcode     in  4          operation select (see ula_pkg)
//   out        out DATA_SIZE  result of the operation sampled one edge earlier
module ula
  import ula_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] operand_a,
  input  logic [DATA_SIZE-1:0] operand_b,
  input  logic [OPCODE_W-1:0]  opcode,
  output logic [DATA_SIZE-1:0] out
);

  localparam int unsigned W = DATA_SIZE;

  logic [W-1:0] quot_c;
  logic         div_zero_c;
  logic         a_nz_c;
  logic         b_nz_c;
  cmp_res_e     cmp_c;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;

  ula_div #(
    .W (W)
  ) u_div (
    .dividend      (operand_a),
    .divisor       (operand_b),
    .quotient_c    (quot_c),
    .div_by_zero_c (div_zero_c)
  );

  // Operation mux; all arithmetic is evaluated at W bits so carries wrap
  always_comb begin
    out_d  = '0;
    a_nz_c = (operand_a != '0);
    b_nz_c = (operand_b != '0);
    cmp_c  = cmp_encode(operand_a > operand_b, operand_a == operand_b);
    unique case (opcode)
      OP_ADD:  out_d = operand_a + operand_b;
      OP_SUB:  out_d = operand_a - operand_b;
      OP_MUL:  out_d = operand_a * operand_b;
      OP_DIV:  out_d = div_zero_c ? '1 : quot_c;
      OP_AND:  out_d = W'(a_nz_c && b_nz_c);
      OP_NAND: out_d = W'(!(a_nz_c && b_nz_c));
      OP_OR:   out_d = W'(a_nz_c || b_nz_c);
      OP_XOR:  out_d = operand_a ^ operand_b;
      // Sign-extending the 2-bit code gives 0, 1 or all ones
      OP_CMP:  out_d = W'($signed(cmp_c));
      OP_NOT:  out_d = W'(!a_nz_c);
      default: out_d = '0;
    endcase
  end

  // Result register; reset wins over any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : ula

// File: tb/tb_ula.sv
// Self-checking bench for ula: directed vector table, reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_ula;

  localparam int unsigned D    = 11;
  localparam longint      MAXV = (longint'(1) << D) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [D-1:0] a;
  logic [D-1:0] b;
  logic [3:0]   op;
  logic [D-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula #(
    .DATA_SIZE (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (a),
    .operand_b (b),
    .opcode    (op),
    .out       (out)
  );

  typedef struct {
    logic [3:0]   op;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic [D-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int o, input int x, input int y,
                              input int e, input string n);
    vec_t v;
    v.op   = 4'(o);
    v.a    = D'(x);
    v.b    = D'(y);
    v.exp  = D'(e);
    v.name = n;
    return v;
  endfunction

  // Reference model: plain integer arithmetic reduced modulo 2^D
  function automatic longint model(input int o, input longint x, input longint y);
    longint r;
    case (o)
      0: r = (x + y) % (MAXV + 1);
      1: r = (x - y + (MAXV + 1)) % (MAXV + 1);
      2: r = (x * y) % (MAXV + 1);
      3: r = (y == 0) ? MAXV : x / y;
      4: r = (x != 0 && y != 0) ? 1 : 0;
      5: r = (x != 0 && y != 0) ? 0 : 1;
      6: r = (x != 0 || y != 0) ? 1 : 0;
      7: r = x ^ y;
      8: r = (x > y) ? 1 : ((x == y) ? 0 : MAXV);
      9: r = (x == 0) ? 1 : 0;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [D-1:0] got,
                       input logic [D-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out=%0d expected %0d", name, got, exp);
    end
  endtask

  // Present inputs away from the edge, then move to just after the next edge
  task automatic step(input int o, input int x, input int y);
    @(negedge clk);
    op = 4'(o);
    a  = D'(x);
    b  = D'(y);
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_operand();
    int sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0: return 0;
      1: return int'(MAXV);
      2: return 1;
      default: return int'($urandom_range(0, int'(MAXV)));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    op  = '0;
    a   = '0;
    b   = '0;

    vecs.push_back(mk(0, 10, 20, 30, "add_10_20"));
    vecs.push_back(mk(1, 20, 10, 10, "sub_20_10"));
    vecs.push_back(mk(1, 10, 20, 2038, "sub_10_20"));
    vecs.push_back(mk(2, 24, 25, 600, "mul_24_25"));
    vecs.push_back(mk(2, 2047, 2, 2046, "mul_2047_2"));
    vecs.push_back(mk(2, 2047, 2047, 1, "mul_max_max"));
    vecs.push_back(mk(3, 13, 5, 2, "div_13_5"));
    vecs.push_back(mk(3, 7, 0, 2047, "div_7_0"));
    vecs.push_back(mk(3, 0, 0, 2047, "div_0_0"));
    vecs.push_back(mk(3, 2047, 1, 2047, "div_max_1"));
    vecs.push_back(mk(4, 'h55, 'hAA, 1, "and_55_aa"));
    vecs.push_back(mk(5, 'h55, 'hAA, 0, "nand_55_aa"));
    vecs.push_back(mk(6, 'h55, 'hAA, 1, "or_55_aa"));
    vecs.push_back(mk(7, 'h55, 'hAA, 'hFF, "xor_55_aa"));
    vecs.push_back(mk(4, 0, 5, 0, "and_0_5"));
    vecs.push_back(mk(5, 0, 5, 1, "nand_0_5"));
    vecs.push_back(mk(6, 0, 0, 0, "or_0_0"));
    vecs.push_back(mk(9, 0, 77, 1, "not_0"));
    vecs.push_back(mk(9, 123, 0, 0, "not_123"));
    vecs.push_back(mk(8, 123, 122, 1, "cmp_gt"));
    vecs.push_back(mk(8, 123, 124, 2047, "cmp_lt"));
    vecs.push_back(mk(8, 123, 123, 0, "cmp_eq"));
    vecs.push_back(mk(8, 2047, 2047, 0, "cmp_eq_max"));
    vecs.push_back(mk(12, 100, 200, 0, "rsvd_12"));
    vecs.push_back(mk(15, 2047, 2047, 0, "rsvd_15"));
    vecs.push_back(mk(0, 2047, 1, 0, "add_wrap"));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, '0);

    // Reset held with a live operation still forces zero
    step(0, 100, 200);
    check("reset_hold_add", out, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      step(int'(vecs[i].op), int'(vecs[i].a), int'(vecs[i].b));
      check(vecs[i].name, out, vecs[i].exp);
    end

    // Mid-stream reset with ADD active, then release
    step(0, 5, 6);
    check("pre_reset_add", out, D'(11));
    @(negedge clk);
    op  = 4'd0;
    a   = D'(300);
    b   = D'(400);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_zero", out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_sum", out, D'(700));

    // Back-to-back operations: each result tracks only the previous edge
    step(2, 3, 4);
    check("b2b_mul", out, D'(12));
    step(3, 100, 7);
    check("b2b_div", out, D'(14));

    // Randomized operations against the reference model
    for (int n = 0; n < 400; n++) begin
      int o;
      int x;
      int y;
      o = int'($urandom_range(0, 15));
      x = pick_operand();
      y = pick_operand();
      step(o, x, y);
      check($sformatf("rand_op%0d_a%0d_b%0d", o, x, y), out,
            D'(model(o, longint'(x), longint'(y))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ula
